// File: rtl/rv523_pkg.sv
// Shared types and helpers for the scan register slice.
package rv523_pkg;

  // Controller states of the scan register.
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } scan_state_t;

  // Per-bit input selection for a storage cell.
  typedef enum logic [1:0] {
    OP_HOLD  = 2'd0,
    OP_LOAD  = 2'd1,
    OP_SHIFT = 2'd2
  } cell_op_t;

  // Ceiling log2, usable in parameter expressions.
  // Returns at least 1 so derived widths never collapse to zero.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    if (r < 1) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/scan_reg_cell.sv
// One storage bit with a hold / parallel-load / shift-in input mux.
// Async active-high reset to a per-bit value.
module scan_cell
  import rv523_pkg::*;
#(
  parameter logic RST_BIT = 1'b0
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  cell_op_t op_i,
  input  logic     d_i,
  input  logic     si_i,
  output logic     q_o
);

  logic q_q;
  logic q_d;

  // Select the next value of this bit from the requested operation.
  always_comb begin
    q_d = q_q;
    case (op_i)
      OP_LOAD:  q_d = d_i;
      OP_SHIFT: q_d = si_i;
      default:  q_d = q_q;
    endcase
  end

  // Storage flop; reset forces the bit to its reset value.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) q_q <= RST_BIT;
    else       q_q <= q_d;
  end

  assign q_o = q_q;

endmodule

// File: rtl/scan_reg.sv
// WIDTH-bit register with hold, parallel load and LSB-first scan shift.
// The controller counts exactly WIDTH shifts per sequence, regardless of
// how many cycles are stalled, then pulses DONE for one cycle.
module scan_reg
  import rv523_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               CNT_W     = clog2(WIDTH + 1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] D,
  input  logic             LOAD,
  input  logic             SHIFT_START,
  input  logic             STALL,
  input  logic             SI,
  output logic [WIDTH-1:0] Q,
  output logic             SO,
  output logic             BUSY,
  output logic             DONE
);

  scan_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  cell_op_t         op;
  logic [WIDTH-1:0] shin;

  // Next-state, counter and cell operation; LOAD outranks SHIFT_START in IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    op      = OP_HOLD;
    case (state_q)
      IDLE: begin
        if (LOAD) begin
          op = OP_LOAD;
        end else if (SHIFT_START) begin
          state_d = SHIFT;
          cnt_d   = CNT_W'(WIDTH);
        end
      end
      SHIFT: begin
        if (!STALL) begin
          op    = OP_SHIFT;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Controller registers; reset abandons any scan without a DONE pulse.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // Storage bits: each bit shifts in from its upper neighbour, MSB from SI.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    if (i == WIDTH - 1) begin : g_msb
      assign shin[i] = SI;
    end else begin : g_lo
      assign shin[i] = Q[i+1];
    end
    scan_cell #(
      .RST_BIT (RESET_VAL[i])
    ) u_cell (
      .clk_i (CLK),
      .rst_i (RST),
      .op_i  (op),
      .d_i   (D[i]),
      .si_i  (shin[i]),
      .q_o   (Q[i])
    );
  end

  assign SO   = Q[0];
  assign BUSY = (state_q == SHIFT);
  assign DONE = done_q;

endmodule

// File: tb/tb_scan_reg.sv
// Self-checking bench for scan_reg (WIDTH=8, RESET_VAL=8'hA5).
module tb_scan_reg;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] D;
  logic       LOAD;
  logic       SHIFT_START;
  logic       STALL;
  logic       SI;
  logic [7:0] Q;
  logic       SO;
  logic       BUSY;
  logic       DONE;

  int checks = 0;
  int errors = 0;

  logic       so_exp_q[$];
  logic [7:0] q_exp_q[$];

  scan_reg #(
    .WIDTH     (8),
    .RESET_VAL (8'hA5)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .D           (D),
    .LOAD        (LOAD),
    .SHIFT_START (SHIFT_START),
    .STALL       (STALL),
    .SI          (SI),
    .Q           (Q),
    .SO          (SO),
    .BUSY        (BUSY),
    .DONE        (DONE)
  );

  always #5 CLK = ~CLK;

  // Runs one scan sequence from a bench-known register value. Expected SO
  // bits and final Q are queued up front and consumed as the DUT shifts.
  task automatic run_scan(input string name, input logic [7:0] cur_q,
                          input logic [7:0] si_bits, input logic [15:0] stall_mask,
                          input bit load_during, output int busy_cnt,
                          output int done_cnt);
    int shifts;
    int idx;
    logic exp_so;
    logic [7:0] exp_q;
    so_exp_q.delete();
    q_exp_q.delete();
    for (int i = 0; i < 8; i++) so_exp_q.push_back(cur_q[i]);
    q_exp_q.push_back(si_bits);
    busy_cnt = 0;
    done_cnt = 0;
    shifts   = 0;
    idx      = 0;
    @(negedge CLK);
    SHIFT_START = 1'b1;
    @(negedge CLK);
    SHIFT_START = 1'b0;
    for (int c = 0; c < 16; c++) begin
      if (BUSY) begin
        busy_cnt++;
        if (idx < 16 && stall_mask[idx]) begin
          STALL = 1'b1;
        end else begin
          STALL = 1'b0;
          checks++;
          if (so_exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s extra_shift: shift %0d beyond expected 8", name, shifts);
          end else begin
            exp_so = so_exp_q.pop_front();
            if (SO !== exp_so) begin
              errors++;
              $display("FAIL %s so[%0d]: got %b expected %b", name, shifts, SO, exp_so);
            end
          end
          SI = (shifts < 8) ? si_bits[shifts] : 1'b0;
          shifts++;
        end
        LOAD = load_during;
        D    = 8'hFF;
        idx++;
      end else begin
        STALL = 1'b0;
        LOAD  = 1'b0;
      end
      if (DONE) done_cnt++;
      @(negedge CLK);
    end
    STALL = 1'b0;
    LOAD  = 1'b0;
    SI    = 1'b0;
    checks++;
    if (so_exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s timeout: %0d shifts still pending", name, so_exp_q.size());
    end
    exp_q = q_exp_q.pop_front();
    checks++;
    if (Q !== exp_q) begin
      errors++;
      $display("FAIL %s final_q: got %h expected %h", name, Q, exp_q);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1; D = '0; LOAD = 0; SHIFT_START = 0; STALL = 0; SI = 0;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    checks++;
    if (Q !== 8'hA5) begin errors++; $display("FAIL reset_init_q: got %h expected a5", Q); end
    // disturb Q, then reset mid-cycle and check before the next edge
    D = 8'h11; LOAD = 1'b1;
    @(negedge CLK);
    LOAD = 1'b0;
    @(posedge CLK);
    #2 RST = 1'b1;
    #1;
    checks++;
    if (Q !== 8'hA5) begin errors++; $display("FAIL reset_q: got %h expected a5", Q); end
    checks++;
    if (SO !== 1'b1) begin errors++; $display("FAIL reset_so: got %b expected 1", SO); end
    checks++;
    if (BUSY !== 1'b0 || DONE !== 1'b0) begin
      errors++; $display("FAIL reset_ctl: got busy=%b done=%b expected 0 0", BUSY, DONE);
    end
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic test_load();
    @(negedge CLK);
    D = 8'h3C; LOAD = 1'b1;
    @(negedge CLK);
    LOAD = 1'b0; D = 8'h00;
    checks++;
    if (Q !== 8'h3C) begin errors++; $display("FAIL load_q: got %h expected 3c", Q); end
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      checks++;
      if (Q !== 8'h3C || BUSY !== 1'b0) begin
        errors++; $display("FAIL load_hold[%0d]: got q=%h busy=%b expected 3c 0", i, Q, BUSY);
      end
    end
  endtask

  task automatic test_scan();
    int b, d;
    run_scan("scan", 8'h3C, 8'b0100_1101, 16'h0000, 1'b0, b, d);
    checks++;
    if (b != 8) begin errors++; $display("FAIL scan_busy: got %0d cycles expected 8", b); end
    checks++;
    if (d != 1) begin errors++; $display("FAIL scan_done: got %0d pulses expected 1", d); end
    checks++;
    if (Q !== 8'h4D) begin errors++; $display("FAIL scan_q: got %h expected 4d", Q); end
  endtask

  task automatic test_stall();
    int b, d;
    // stall on the 3rd and 6th busy cycles
    run_scan("stall", 8'h4D, 8'b0100_1101, 16'b0000_0000_0010_0100, 1'b0, b, d);
    checks++;
    if (b != 10) begin errors++; $display("FAIL stall_busy: got %0d cycles expected 10", b); end
    checks++;
    if (d != 1) begin errors++; $display("FAIL stall_done: got %0d pulses expected 1", d); end
  endtask

  task automatic test_priority();
    @(negedge CLK);
    D = 8'h5A; LOAD = 1'b1; SHIFT_START = 1'b1;
    @(negedge CLK);
    LOAD = 1'b0; SHIFT_START = 1'b0;
    checks++;
    if (Q !== 8'h5A) begin errors++; $display("FAIL prio_q: got %h expected 5a", Q); end
    checks++;
    if (BUSY !== 1'b0) begin errors++; $display("FAIL prio_busy: got %b expected 0", BUSY); end
    @(negedge CLK);
    checks++;
    if (BUSY !== 1'b0) begin errors++; $display("FAIL prio_dropped: got busy=%b expected 0", BUSY); end
  endtask

  task automatic test_load_during_shift();
    int b, d;
    run_scan("ldshift", 8'h5A, 8'b0100_1101, 16'h0000, 1'b1, b, d);
    checks++;
    if (b != 8 || d != 1) begin
      errors++; $display("FAIL ldshift_ctl: got busy=%0d done=%0d expected 8 1", b, d);
    end
  endtask

  task automatic test_reset_mid_scan();
    int shifts;
    int dn;
    int b, d;
    shifts = 0;
    dn = 0;
    @(negedge CLK);
    SHIFT_START = 1'b1;
    @(negedge CLK);
    SHIFT_START = 1'b0;
    for (int c = 0; c < 10 && shifts < 4; c++) begin
      if (BUSY) begin SI = 1'b1; shifts++; end
      if (shifts < 4) @(negedge CLK);
    end
    @(posedge CLK);
    #2 RST = 1'b1;
    #1;
    checks++;
    if (Q !== 8'hA5 || BUSY !== 1'b0 || DONE !== 1'b0) begin
      errors++; $display("FAIL midrst: got q=%h busy=%b done=%b expected a5 0 0", Q, BUSY, DONE);
    end
    @(negedge CLK);
    RST = 1'b0; SI = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge CLK);
      if (DONE || BUSY) dn++;
    end
    checks++;
    if (dn != 0) begin errors++; $display("FAIL midrst_quiet: got %0d active cycles expected 0", dn); end
    run_scan("rescan", 8'hA5, 8'hC3, 16'h0000, 1'b0, b, d);
    checks++;
    if (b != 8 || d != 1) begin
      errors++; $display("FAIL rescan_ctl: got busy=%0d done=%0d expected 8 1", b, d);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_scan();
    test_stall();
    test_priority();
    test_load_during_shift();
    test_reset_mid_scan();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
